// File: rtl/tt_codelock_pkg.sv
// Shared types and key decoding for the keypad code-lock controller.
package tt_codelock_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CHECK   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe, followed by a rising-edge pulse.
module tt_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchroniser chain plus delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
            prev_r  <= RESET_VAL;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/tt_codelock.sv
// Keypad code-lock: collects digits from an asynchronous key strobe, checks
// the entry on Enter, and drives an unlock window or a timed lockout.
module tt_codelock
    import tt_codelock_pkg::*;
#(
    parameter int                  DIGITS         = 4,
    parameter logic [DIGITS*4-1:0] CODE           = 16'h1234,
    parameter int                  UNLOCK_CYCLES  = 16,
    parameter int                  LOCKOUT_CYCLES = 64,
    parameter int                  MAX_FAILS      = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample,
    input  logic [3:0]                   samplednum,
    output logic                         unlocked,
    output logic                         lockout,
    output logic                         err,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count
);

    localparam int BW   = DIGITS * 4;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int FW   = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;

    localparam logic [CW-1:0] FULL_COUNT   = CW'(DIGITS);
    localparam logic [CW-1:0] COUNT_ONE    = CW'(1);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_ONE     = FW'(1);
    localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAILS - 1);

    state_t          state_r;
    logic [BW-1:0]   buf_r;
    logic [CW-1:0]   count_r;
    logic [FW-1:0]   fail_r;
    logic [TW-1:0]   timer_r;
    logic            unlocked_r;
    logic            lockout_r;
    logic            err_r;
    logic            accept_s;

    tt_sync_edge #(
        .RESET_VAL (1'b1)
    ) u_sample_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sample),
        .pulse    (accept_s)
    );

    // Main controller: entry buffer, code check, unlock window and lockout timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ENTRY;
            buf_r      <= '0;
            count_r    <= '0;
            fail_r     <= '0;
            timer_r    <= '0;
            unlocked_r <= 1'b0;
            lockout_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ENTRY: begin
                    if (accept_s) begin
                        if (is_digit(samplednum)) begin
                            if (count_r < FULL_COUNT) begin
                                buf_r   <= {buf_r[BW-5:0], samplednum};
                                count_r <= count_r + COUNT_ONE;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else if (samplednum == KEY_CLEAR) begin
                            buf_r   <= '0;
                            count_r <= '0;
                        end else if (samplednum == KEY_ENTER) begin
                            if (count_r == FULL_COUNT) begin
                                state_r <= CHECK;
                            end else begin
                                err_r   <= 1'b1;
                                buf_r   <= '0;
                                count_r <= '0;
                            end
                        end else begin
                            state_r <= ENTRY;
                        end
                    end else begin
                        state_r <= ENTRY;
                    end
                end

                // Single-cycle evaluation; any key accepted here is dropped.
                CHECK: begin
                    buf_r   <= '0;
                    count_r <= '0;
                    if (buf_r == CODE) begin
                        state_r    <= OPEN;
                        fail_r     <= '0;
                        timer_r    <= UNLOCK_LOAD;
                        unlocked_r <= 1'b1;
                    end else if (fail_r == FAIL_LAST) begin
                        state_r   <= LOCKOUT;
                        fail_r    <= '0;
                        timer_r   <= LOCKOUT_LOAD;
                        lockout_r <= 1'b1;
                    end else begin
                        state_r <= ENTRY;
                        fail_r  <= fail_r + FAIL_ONE;
                        err_r   <= 1'b1;
                    end
                end

                OPEN: begin
                    if ((accept_s && (samplednum == KEY_CLEAR)) || (timer_r == '0)) begin
                        state_r    <= ENTRY;
                        timer_r    <= '0;
                        unlocked_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end

                LOCKOUT: begin
                    if (timer_r == '0) begin
                        state_r   <= ENTRY;
                        lockout_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end

                default: begin
                    state_r    <= ENTRY;
                    buf_r      <= '0;
                    count_r    <= '0;
                    timer_r    <= '0;
                    unlocked_r <= 1'b0;
                    lockout_r  <= 1'b0;
                end
            endcase
        end
    end

    assign unlocked    = unlocked_r;
    assign lockout     = lockout_r;
    assign err         = err_r;
    assign digit_count = count_r;

endmodule

// File: tb/tb_tt_codelock.sv
// Directed and randomized key sequences against a key-level reference model of the lock.
module tb_tt_codelock;

    logic       clk;
    logic       rst_n;
    logic       sample;
    logic [3:0] samplednum;
    logic       unlocked;
    logic       lockout;
    logic       err;
    logic [2:0] digit_count;

    int passed = 0;
    int total  = 0;

    // Reference model state, expressed in keys and remaining cycles.
    int  m_open;
    int  m_lock;
    int  m_fails;
    bit  m_check;
    bit  m_err;
    int  m_dig[$];
    int  code_digits[4] = '{1, 2, 3, 4};

    tt_codelock dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample      (sample),
        .samplednum  (samplednum),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .err         (err),
        .digit_count (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_open  = 0;
        m_lock  = 0;
        m_fails = 0;
        m_check = 0;
        m_err   = 0;
        m_dig.delete();
    endtask

    function automatic bit entry_matches();
        if (m_dig.size() != 4) return 0;
        for (int i = 0; i < 4; i++)
            if (m_dig[i] != code_digits[i]) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit acc, input int key);
        m_err = 0;
        if (m_check) begin
            m_check = 0;
            if (entry_matches()) begin
                m_open  = 16;
                m_fails = 0;
            end else begin
                m_fails++;
                if (m_fails == 3) begin
                    m_lock  = 64;
                    m_fails = 0;
                end else begin
                    m_err = 1;
                end
            end
            m_dig.delete();
        end else if (m_open > 0) begin
            if (acc && key == 12) m_open = 0;
            else m_open--;
        end else if (m_lock > 0) begin
            m_lock--;
        end else if (acc) begin
            if (key <= 9) begin
                if (m_dig.size() < 4) m_dig.push_back(key);
                else m_err = 1;
            end else if (key == 12) begin
                m_dig.delete();
            end else if (key == 14) begin
                if (m_dig.size() == 4) m_check = 1;
                else begin
                    m_err = 1;
                    m_dig.delete();
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        chk("unlocked",    int'(unlocked),    (m_open > 0) ? 1 : 0);
        chk("lockout",     int'(lockout),     (m_lock > 0) ? 1 : 0);
        chk("err",         int'(err),         int'(m_err));
        chk("digit_count", int'(digit_count), m_dig.size());
    endtask

    task automatic tick(input bit acc, input int key);
        @(posedge clk);
        model_step(acc, key);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0);
    endtask

    // Strobe rises at a falling edge; the key is acted on at the third rising edge.
    task automatic press(input int key);
        @(negedge clk);
        samplednum = 4'(key);
        sample     = 1'b1;
        tick(0, 0);
        tick(0, 0);
        tick(1, key);
        @(negedge clk);
        sample = 1'b0;
        idle(2 + int'($urandom_range(0, 2)));
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d); press(14);
    endtask

    task automatic enter_wrong();
        enter_code(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                   int'($urandom_range(0, 9)), 5);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
    endtask

    initial begin
        rst_n      = 1'b0;
        sample     = 1'b1;
        samplednum = 4'h1;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        @(negedge clk);
        sample = 1'b0;
        idle(3);

        enter_code(1, 2, 3, 4);
        idle(20);

        enter_wrong();
        enter_wrong();
        enter_wrong();
        enter_code(1, 2, 3, 4);
        idle(40);
        enter_code(1, 2, 3, 4);
        idle(20);

        press(1); press(2); press(14);
        press(1); press(2); press(3); press(4); press(5);
        press(14);
        idle(20);

        press(1); press(2); press(12); press(10);
        press(1); press(2); press(15); press(3); press(4); press(14);
        idle(5);
        press(11);
        press(12);
        idle(5);

        enter_code(1, 2, 3, 4);
        idle(5);
        async_reset();
        enter_wrong();
        enter_wrong();
        enter_wrong();
        idle(10);
        async_reset();
        enter_wrong();
        enter_wrong();
        async_reset();
        enter_wrong();
        enter_wrong();
        enter_code(1, 2, 3, 4);
        idle(20);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                enter_code(1, 2, 3, 4);
            end else begin
                int len;
                len = int'($urandom_range(1, 6));
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 4) == 0) press(int'($urandom_range(10, 15)));
                    else press(int'($urandom_range(0, 9)));
                end
                press(14);
            end
            idle(int'($urandom_range(0, 20)));
        end
        idle(80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tt_codelock.md
# tt_codelock

Keypad code-lock controller; consumes the 4-bit key nibble produced by `tt_samplekey` on its `samplednum` output. That nibble is registered in the `sample` domain. This block brings the `sample` strobe into `clk`, accepts one nibble per strobe, and collects digits into a DIGITS-long entry buffer. On an Enter key it compares the entry with a stored code and drives an unlock window, or counts the failure and enters a timed lockout after repeated failures.

## Interface
- `DIGITS`, 4: code length in decimal digits
- `CODE`, 16'h1234: stored code, DIGITS*4 bits, one digit per nibble, first-entered digit in the MS nibble
- `UNLOCK_CYCLES`, 16: clk cycles `unlocked` stays high
- `LOCKOUT_CYCLES`, 64: clk cycles `lockout` stays high
- `MAX_FAILS`, 3: consecutive mismatches that trigger lockout (≥1)

Ports:
- `clk` in 1: single clock; every flop in the block is on it
- `rst_n` in 1: asynchronous, active-low reset
- `sample` in 1: key strobe from the upstream domain; asynchronous to `clk`
- `samplednum` in 4: key nibble; stable from each `sample` rise until the next
- `unlocked` out 1: code accepted; high for the unlock window
- `lockout` out 1: too many failures; input ignored
- `err` out 1: one-cycle pulse on a rejected entry or keystroke
- `digit_count` out $clog2(DIGITS+1): digits currently buffered

## Operation
- Key decode:
  - 0x0–0x9: digit
  - 0xC: Clear
  - 0xE: Enter
  - 0xA, 0xB, 0xD, 0xF: silently ignored (no `err`)
- States: ENTRY, CHECK, OPEN, LOCKOUT. Reset state is ENTRY.
- ENTRY:
  - Digit with count<DIGITS: buffer = {buffer[DIGITS*4-5:0], nibble}; count+1.
  - Digit with count==DIGITS: ignored, `err` pulse.
  - Clear: buffer=0, count=0.
  - Enter with count==DIGITS: go to CHECK.
  - Enter with count<DIGITS: `err` pulse, buffer=0, count=0, stay in ENTRY.
- CHECK (exactly one cycle, no key accepted):
  - buffer==CODE: go to OPEN, fail_cnt=0, timer=UNLOCK_CYCLES-1.
  - Mismatch with fail_cnt+1==MAX_FAILS: go to LOCKOUT, fail_cnt=0, timer=LOCKOUT_CYCLES-1.
  - Any other mismatch: fail_cnt+1, `err` pulse, back to ENTRY.
  - buffer and count are cleared on every exit from CHECK.
- OPEN:
  - `unlocked`=1.
  - Clear ends the window; next cycle is ENTRY with `unlocked`=0.
  - All other keys are ignored.
  - When timer==0, go to ENTRY; otherwise decrement timer.
- LOCKOUT:
  - `lockout`=1.
  - All keys are ignored, with no `err`.
  - When timer==0, go to ENTRY; otherwise decrement timer.
- fail_cnt survives Clear and OPEN timeout. It is zeroed only by reset, a match, or entering LOCKOUT.

## Timing
- Strobe path: two synchroniser flops, then a prev flop. accept = sync2 & ~prev.
- Latency: a nibble is acted on at the 3rd rising `clk` after `sample` rises. `samplednum` is read directly at that edge; it has been stable for at least 2 cycles.
- The sync and prev flops reset to 1. A `sample` held high through reset release produces no acceptance. Only a low-then-high transition is accepted.
- An accept that lands in CHECK is dropped.
- At most one nibble per accept. A strobe shorter than 2 clk cycles may be missed; this is allowed.
- Enter accepted at edge N:
  - CHECK during cycle N..N+1.
  - On a match, `unlocked` rises after edge N+1 and stays high exactly UNLOCK_CYCLES cycles.
  - The `err` or `lockout` outcome takes effect after edge N+1.
- `err` is registered and high for exactly one cycle per event.
- Reset values: `unlocked`=0, `lockout`=0, `err`=0, `digit_count`=0; buffer, fail_cnt and timer = 0.
- Asserting `rst_n` low mid-operation clears all outputs immediately (asynchronous).
- Timer width: $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)). It counts down only in OPEN and LOCKOUT.

## Structure
- `tt_codelock_pkg` holds:
  - the state enum (ENTRY, CHECK, OPEN, LOCKOUT)
  - `KEY_CLEAR`=4'hC and `KEY_ENTER`=4'hE
  - an `is_digit` function
- Sub-module `tt_sync_edge`: 2-flop synchroniser plus rising-edge pulse, with a reset-value parameter (here 1). It is reused for any other asynchronous strobe in the design.
- Everything else lives in one FSM/datapath module.

## Test plan
- Hold `sample` high across reset release, then keep it high for 20 cycles → no accept; all outputs 0 and `digit_count`=0.
- Keys 1,2,3,4,E → `digit_count` steps 1..4; `unlocked` high for exactly 16 cycles starting 2 edges after the E accept; `err` never pulses.
- Keys 1,2,3,5,E three times (MAX_FAILS=3):
  - `err` pulses after the 1st and 2nd entries.
  - After the 3rd, `lockout` is high for 64 cycles and keys entered meanwhile have no effect.
  - Then 1,2,3,4,E unlocks.
- Keys 1,2,E → `err` pulse and count 0. Then 1,2,3,4,5 → `err` on the 5th key and count stays 4. Then E → unlock.
- Keys 1,2,C,1,2,3,4,E → unlock. Clear during OPEN → `unlocked` low on the next cycle. A and F keys anywhere → no state change.
- Pull `rst_n` low mid-OPEN, and again mid-LOCKOUT → outputs drop immediately without waiting for `clk`; after release, fail_cnt=0 (needs 3 new failures to lock).
